// File: rtl/dds_pkg.sv
// dds_pkg: shared sample width and capture FSM state type for the DDS sample capture path.
package dds_pkg;
  localparam int SAMPLE_W = 16;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} cap_state_t;
endpackage

// File: rtl/dds_cap_fifo.sv
// dds_cap_fifo: DEPTH x W synchronous FIFO with flush, occupancy count and registered read data.
module dds_cap_fifo import dds_pkg::*; #(
  parameter int W = SAMPLE_W,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd,
  output logic [W-1:0]               rd_data,
  output logic                       rd_vld,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_wr, do_rd;
  assign do_wr = wr & ~flush & (count != (AW+1)'(DEPTH));
  assign do_rd = rd & ~flush & (count != '0);
  always_ff @(posedge clk)
    if (do_wr) mem[wp] <= wr_data;
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      rd_data <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= do_rd;
      if (do_rd) rd_data <= mem[rp];
      if (flush) begin
        wp <= '0;
        rp <= '0;
        count <= '0;
      end else begin
        wp <= wp + AW'(do_wr);
        rp <= rp + AW'(do_rd);
        count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      end
    end
endmodule

// File: rtl/dds_sample_capture.sv
// dds_sample_capture: captures a decimated burst of DDS samples into a FIFO for host readout.
// Define DDS_CAP_TRIGGER_EN to start each burst on a rising zero-crossing of the sample stream.
module dds_sample_capture #(
  parameter int SAMPLE_W = dds_pkg::SAMPLE_W,
  parameter int DEPTH = 16,
  parameter int DECIM_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SAMPLE_W-1:0]      sample_i,
  input  logic                     sample_vld_i,
  input  logic                     arm_i,
  input  logic [DECIM_W-1:0]       decim_i,
  input  logic                     rd_req_i,
  output logic [SAMPLE_W-1:0]      rd_data_o,
  output logic                     rd_vld_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     underflow_o
);
  import dds_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
  cap_state_t state;
  logic arm_prev, rd_prev, arm_edge, rd_edge;
  logic [DECIM_W-1:0] decim_q, dcnt;
  logic [CW-1:0] wr_cnt;
  logic start, trig, cap_wr, wr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      arm_prev <= 1'b0;
      rd_prev <= 1'b0;
      arm_edge <= 1'b0;
      rd_edge <= 1'b0;
    end else begin
      arm_prev <= arm_i;
      rd_prev <= rd_req_i;
      arm_edge <= arm_i & ~arm_prev;
      rd_edge <= rd_req_i & ~rd_prev;
    end
  assign start = arm_edge & (state == IDLE || state == DONE);
`ifdef DDS_CAP_TRIGGER_EN
  logic prev_sign;
  assign trig = (state == ARMED) & sample_vld_i & prev_sign & ~sample_i[SAMPLE_W-1];
`else
  assign trig = 1'b0;
`endif
  // the write that completes the burst is followed by one cycle in CAPTURE that must not write
  assign cap_wr = (state == CAPTURE) & sample_vld_i & (dcnt == '0) & (wr_cnt != CW'(DEPTH));
  assign wr = cap_wr | trig;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      underflow_o <= 1'b0;
      decim_q <= '0;
      dcnt <= '0;
      wr_cnt <= '0;
`ifdef DDS_CAP_TRIGGER_EN
      prev_sign <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: if (arm_edge) begin
          state <= ARMED;
          busy_o <= 1'b1;
          done_o <= 1'b0;
          decim_q <= decim_i;
          dcnt <= '0;
          wr_cnt <= '0;
`ifdef DDS_CAP_TRIGGER_EN
          prev_sign <= 1'b0;
`endif
        end
        ARMED: begin
`ifdef DDS_CAP_TRIGGER_EN
          if (sample_vld_i) prev_sign <= sample_i[SAMPLE_W-1];
          if (trig) begin
            state <= CAPTURE;
            dcnt <= decim_q;
            wr_cnt <= CW'(1);
          end
`else
          state <= CAPTURE;
`endif
        end
        default: if (wr_cnt == CW'(DEPTH)) begin
          state <= DONE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end else if (sample_vld_i) begin
          dcnt <= (dcnt == '0) ? decim_q : dcnt - DECIM_W'(1);
          wr_cnt <= wr_cnt + CW'(cap_wr);
        end
      endcase
      underflow_o <= start ? 1'b0 : (underflow_o | (rd_edge & (count_o == '0)));
    end
  dds_cap_fifo #(.W(SAMPLE_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(start),
    .wr(wr),
    .wr_data(sample_i),
    .rd(rd_edge),
    .rd_data(rd_data_o),
    .rd_vld(rd_vld_o),
    .count(count_o)
  );
endmodule

// File: tb/tb_dds_sample_capture.sv
// tb_dds_sample_capture: table-driven, directed and randomized checks of dds_sample_capture.
module tb_dds_sample_capture;
  logic clk = 1'b0, rst_n = 1'b0, sample_vld_i = 1'b0, arm_i = 1'b0, rd_req_i = 1'b0;
  logic [15:0] sample_i = '0;
  logic [7:0] decim_i = '0;
  logic [15:0] rd_data_o;
  logic rd_vld_o, busy_o, done_o, underflow_o;
  logic [4:0] count_o;
  int checks = 0, errors = 0;
  logic [15:0] last_rd = '0;
  typedef struct {int decim; int gap; int n; int exp_count; int exp_done; int exp_last;} vec_t;
  vec_t tbl[5];
  logic [15:0] q[$], kept[$];
  int d, n, st;
  always #5 clk = ~clk;
  dds_sample_capture dut (
    .clk(clk), .rst_n(rst_n), .sample_i(sample_i), .sample_vld_i(sample_vld_i), .arm_i(arm_i),
    .decim_i(decim_i), .rd_req_i(rd_req_i), .rd_data_o(rd_data_o), .rd_vld_o(rd_vld_o),
    .count_o(count_o), .busy_o(busy_o), .done_o(done_o), .underflow_o(underflow_o)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    sample_vld_i = 1'b0;
    arm_i = 1'b0;
    rd_req_i = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    last_rd = '0;
    cyc(1);
  endtask
  task automatic arm(input int dv);
    decim_i = 8'(dv);
    arm_i = 1'b1;
    cyc(3);
    arm_i = 1'b0;
    cyc(2);
  endtask
  task automatic send(input logic [15:0] v, input int gap);
    sample_i = v;
    sample_vld_i = 1'b1;
    cyc(1);
    sample_vld_i = 1'b0;
    sample_i = 16'($urandom);
    cyc(gap);
  endtask
  // a negative sample ahead of a ramp gives the trigger build its crossing at ramp value 0
  task automatic preamble();
`ifdef DDS_CAP_TRIGGER_EN
    send(16'h8000, 0);
`endif
  endtask
  task automatic pop(input logic exp_vld, input logic [15:0] exp_data, input string name);
    rd_req_i = 1'b1;
    cyc(2);
    chk({name, " vld"}, 32'(rd_vld_o), 32'(exp_vld));
    chk({name, " data"}, 32'(rd_data_o), 32'(exp_vld ? exp_data : last_rd));
    if (exp_vld) last_rd = exp_data;
    rd_req_i = 1'b0;
    cyc(1);
    chk({name, " vld pulse"}, 32'(rd_vld_o), 32'(0));
  endtask
  initial begin
    tbl = '{'{0, 0, 20, 16, 1, 15}, '{2, 1, 61, 16, 1, 45}, '{1, 0, 10, 5, 0, 8},
            '{3, 2, 64, 16, 1, 60}, '{0, 1, 5, 5, 0, 4}};
    cyc(1);
    chk("reset count", 32'(count_o), 0);
    chk("reset flags", {28'(0), rd_vld_o, busy_o, done_o, underflow_o}, 0);
    chk("reset data", 32'(rd_data_o), 0);
    rst_n = 1'b1;
    cyc(1);
    for (int t = 0; t < 5; t++) begin
      do_reset();
      arm(tbl[t].decim);
      chk("tbl busy", 32'(busy_o), 1);
      preamble();
      for (int i = 0; i < tbl[t].n; i++) send(16'(i), tbl[t].gap);
      cyc(3);
      chk("tbl count", 32'(count_o), 32'(tbl[t].exp_count));
      chk("tbl done", 32'(done_o), 32'(tbl[t].exp_done));
      chk("tbl busy end", 32'(busy_o), 32'(1 - tbl[t].exp_done));
      for (int k = 0; k < tbl[t].exp_count; k++) pop(1'b1, 16'(k * (tbl[t].decim + 1)), "tbl pop");
      chk("tbl last", 32'(last_rd), 32'(tbl[t].exp_last));
      pop(1'b0, '0, "tbl empty pop");
      chk("tbl underflow", 32'(underflow_o), 1);
    end
    do_reset();
    arm(0);
    preamble();
    for (int i = 0; i < 5; i++) send(16'(i + 1), 0);
    cyc(2);
    chk("mid count", 32'(count_o), 5);
    rst_n = 1'b0;
    #1;
    chk("mid reset count", 32'(count_o), 0);
    chk("mid reset flags", {28'(0), rd_vld_o, busy_o, done_o, underflow_o}, 0);
    cyc(1);
    rst_n = 1'b1;
    last_rd = '0;
    cyc(1);
    pop(1'b0, '0, "idle after reset pop");
    do_reset();
    arm(0);
    preamble();
    for (int g = 0; g < 4; g++) begin
      for (int j = 0; j < 4; j++) send(16'(4 * g + j), 0);
      pop(1'b1, 16'(g), "cap pop");
    end
    cyc(3);
    chk("cap done", 32'(done_o), 1);
    chk("cap count", 32'(count_o), 12);
    for (int j = 0; j < 4; j++) send(16'(100 + j), 0);
    chk("cap drop count", 32'(count_o), 12);
    pop(1'b1, 16'd4, "cap pop after done");
    do_reset();
    arm(0);
    preamble();
    for (int i = 0; i < 3; i++) send(16'(i), 0);
    arm(5);
    chk("busy arm ignored", 32'(busy_o), 1);
    chk("busy arm count", 32'(count_o), 3);
    for (int i = 3; i < 16; i++) send(16'(i), 0);
    cyc(3);
    chk("busy done", 32'(done_o), 1);
    chk("busy count", 32'(count_o), 16);
    for (int k = 0; k < 16; k++) pop(1'b1, 16'(k), "busy pop");
    pop(1'b0, '0, "busy empty pop");
    chk("busy underflow", 32'(underflow_o), 1);
    arm(0);
    chk("rearm count", 32'(count_o), 0);
    chk("rearm underflow", 32'(underflow_o), 0);
    chk("rearm done", 32'(done_o), 0);
    chk("rearm busy", 32'(busy_o), 1);
    do_reset();
    arm(0);
    send(16'h0100, 0);
    send(16'hFF00, 1);
    send(16'hFFFF, 0);
    send(16'h0002, 2);
    send(16'h0003, 0);
    cyc(3);
`ifdef DDS_CAP_TRIGGER_EN
    chk("trig count", 32'(count_o), 2);
    pop(1'b1, 16'h0002, "trig first");
`else
    chk("trig count", 32'(count_o), 5);
    pop(1'b1, 16'h0100, "trig first");
`endif
    for (int it = 0; it < 6; it++) begin
      d = $urandom_range(3, 0);
      n = 16 * (d + 1) + 4;
      q.delete();
      kept.delete();
      for (int i = 0; i < n; i++) q.push_back(16'($urandom));
      st = 0;
`ifdef DDS_CAP_TRIGGER_EN
      st = n;
      for (int i = n - 1; i >= 1; i--) if (q[i-1][15] && !q[i][15]) st = i;
`endif
      for (int i = st; i < n; i++) if ((i - st) % (d + 1) == 0 && kept.size() < 16) kept.push_back(q[i]);
      do_reset();
      arm(d);
      foreach (q[i]) send(q[i], $urandom_range(2, 0));
      cyc(3);
      chk("rnd count", 32'(count_o), 32'(kept.size()));
      chk("rnd done", 32'(done_o), 32'(kept.size() == 16));
      foreach (kept[i]) pop(1'b1, kept[i], "rnd pop");
      pop(1'b0, '0, "rnd empty pop");
      chk("rnd underflow", 32'(underflow_o), 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
